serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller: sequences a single full-adder cell (FA, one bit per clock) over a WIDTH-bit operand pair, with a registered carry between bits. It latches operands on a start request, runs WIDTH addition cycles, then presents the sum, carry-out and signed overflow with a one-cycle done pulse. The block trades throughput for area: the whole datapath is one FA plus shift registers, a carry flop and a bit counter.

## Interface
- WIDTH, 8, operand/result width in bits (≥1).
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A, latched when start is accepted.
- b  in  WIDTH  operand B, latched when start is accepted.
- cin  in  1  carry-in, latched when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  registered result; holds until next completion.
- cout  out  1  registered carry-out of bit WIDTH-1.
- ovf  out  1  registered signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Internal state: sa, sb shift registers (WIDTH), carry flop, partial-sum shift register, counter ($clog2(WIDTH+1) bits), FSM {IDLE, RUN, DONE}.
- Datapath per RUN cycle: FA inputs A=sa[0], B=sb[0], AE=carry. Partial-sum register shifts right, FA SUMA enters MSB. sa, sb shift right. carry <= FA AS. counter increments.
- IDLE: start=1 → load sa=a, sb=b, carry=cin, counter=0, go RUN. start=0 → stay.
- RUN: on the edge where counter reaches WIDTH-1 (last bit), go DONE; on that same edge load sum with the final shifted partial sum, cout with FA AS, ovf with (carry into MSB) XOR (FA AS), where carry into MSB = current carry flop.
- DONE: done=1 for exactly this cycle; unconditionally go IDLE next edge.
- start is ignored in RUN and DONE (no queueing); a, b, cin changes after acceptance have no effect.
- Partial results never appear on sum/cout/ovf; those change only on the completion edge.
- WIDTH=1: RUN lasts one cycle; ovf = cin XOR cout.

## Timing
- Reset (async, immediate): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, all internal registers 0.
- Reset mid-RUN or in DONE: operation aborted, no done pulse, outputs cleared as above.
- Edge E0 samples start=1 in IDLE → busy=1 after E0.
- Bit i computed between E(i) and E(i+1), i=0..WIDTH-1.
- After E(WIDTH): state DONE, busy=0, done=1, sum/cout/ovf valid.
- After E(WIDTH+1): IDLE, done=0; results held.
- Latency start-accept to done: WIDTH cycles. Earliest next accept: E(WIDTH+2), i.e. one operation every WIDTH+2 cycles max.
- start held continuously: a new operation is accepted each time IDLE is entered, re-latching a/b/cin.
- busy and done never high together; done never high for two consecutive cycles.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start → busy for 8 cycles, done 8 cycles after accept, sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- Accept a=0x10,b=0x20; during RUN pulse start with a=0xFF,b=0xFF and change a/b → single done, sum=0x30, cout=0; second request not executed.
- Assert rst at RUN cycle 4 of a=0xAA,b=0x55 → outputs 0 immediately, no done pulse; after release, a=0x01,b=0x02 → sum=0x03.
- start held high with a=0x01,b=0x01,cin=1 → done every 10 cycles, sum=0x03 each time; sum holds 0x03 between pulses.
- Randomized 1000 operations at WIDTH=8, WIDTH=1 and WIDTH=13 vs. reference {cout,sum}=a+b+cin, ovf from signed comparison.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencing one full-adder cell over a WIDTH-bit operand pair
// Ports: clk, rst (asynchronous, active-high)
//        start, a, b, cin : request and operands; sampled only while idle
//        busy             : high while bits are being added
//        done             : one-cycle pulse, sum/cout/ovf valid
//        sum, cout, ovf   : registered result, held until the next completion
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] sa, sb, ps, ps_n;
    logic [CW-1:0]    cnt;
    logic             carry, fs, fc, last;
    always_comb begin
        fs   = sa[0] ^ sb[0] ^ carry;
        fc   = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
        // new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
        ps_n = (ps >> 1) | (WIDTH'(fs) << (WIDTH - 1));
        last = cnt == CW'(WIDTH - 1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            ps    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    ps    <= ps_n;
                    carry <= fc;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // carry flop still holds the carry into the MSB here
                        sum   <= ps_n;
                        cout  <= fc;
                        ovf   <= carry ^ fc;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
